// File: rtl/mc_arb_pkg.sv
// Shared types and constants for the MC port arbiter.
// Command encodings, response FIFO entry layout and ID sizing.
package mc_arb_pkg;

   localparam logic [2:0] MC_CMD_RD8  = 3'd1;
   localparam logic [2:0] MC_CMD_WR8  = 3'd2;
   localparam logic [2:0] MC_RS_RDRSP = 3'd2;
   localparam logic [2:0] MC_RS_WRCMP = 3'd3;

   // Entry fields sized for the largest supported configuration
   localparam int ID_MAX  = 3;
   localparam int RTN_MAX = 64;

   typedef struct packed {
      logic [ID_MAX-1:0]  id;
      logic [2:0]         cmd;
      logic [3:0]         scmd;
      logic [63:0]        data;
      logic [RTN_MAX-1:0] rtnctl;
   } rsp_entry_t;

   function automatic int id_bits(input int n);
      int b;
      b = 0;
      while ((1 << b) < n) b++;
      return b;
   endfunction

endpackage

// File: rtl/mc_port_arbiter_fifo.sv
// In-order response buffer between the MC response port and requesters.
// Pushes at full are dropped and flagged on a sticky overflow bit.
module mc_rsp_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = mem[rp];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         if (do_push) wp <= wp + AW'(1);
         if (do_pop)  rp <= rp + AW'(1);
         if (do_push & ~do_pop)      count <= count + CW'(1);
         else if (~do_push & do_pop) count <= count - CW'(1);
         if (push & full) ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= wdata;
   end

endmodule

// File: rtl/mc_port_arbiter.sv
// Round-robin share of one MC port among NUM_REQ requesters.
// Requester ID rides in the top rtnctl bits to route responses back.
module mc_port_arbiter
   import mc_arb_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int RTNCTL_WIDTH = 32,
   parameter int ID_W         = id_bits(NUM_REQ),
   parameter int RSP_DEPTH    = 8,
   parameter int RS_SLACK     = 3,
   parameter int MAX_OUTST    = 256
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NUM_REQ-1:0]                  req_vld,
   input  logic [NUM_REQ*3-1:0]                req_cmd,
   input  logic [NUM_REQ*4-1:0]                req_scmd,
   input  logic [NUM_REQ*48-1:0]               req_vadr,
   input  logic [NUM_REQ*2-1:0]                req_size,
   input  logic [NUM_REQ*64-1:0]               req_data,
   input  logic [NUM_REQ*(RTNCTL_WIDTH-ID_W)-1:0] req_rtnctl,
   output logic [NUM_REQ-1:0]                  req_rdy,
   output logic [NUM_REQ-1:0]                  rsp_vld,
   output logic [2:0]                          rsp_cmd,
   output logic [3:0]                          rsp_scmd,
   output logic [63:0]                         rsp_data,
   output logic [RTNCTL_WIDTH-ID_W-1:0]        rsp_rtnctl,
   input  logic [NUM_REQ-1:0]                  rsp_stall,
   output logic                                mc_rq_vld,
   output logic [2:0]                          mc_rq_cmd,
   output logic [3:0]                          mc_rq_scmd,
   output logic [47:0]                         mc_rq_vadr,
   output logic [1:0]                          mc_rq_size,
   output logic [63:0]                         mc_rq_data,
   output logic [RTNCTL_WIDTH-1:0]             mc_rq_rtnctl,
   input  logic                                mc_rq_stall,
   output logic                                mc_rq_flush,
   input  logic                                mc_rs_vld,
   input  logic [2:0]                          mc_rs_cmd,
   input  logic [3:0]                          mc_rs_scmd,
   input  logic [63:0]                         mc_rs_data,
   input  logic [RTNCTL_WIDTH-1:0]             mc_rs_rtnctl,
   output logic                                mc_rs_stall,
   output logic                                idle,
   output logic                                err_ovf
);

   localparam int LW = RTNCTL_WIDTH - ID_W;
   localparam int OW = $clog2(MAX_OUTST + 1);
   localparam int CW = $clog2(RSP_DEPTH) + 1;
   localparam int EW = $bits(rsp_entry_t);

   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] gnt_id;
   logic            gnt_vld;
   logic            can_gnt;
   logic [OW-1:0]   outst;
   logic            outst_dec;
   rsp_entry_t      push_e;
   rsp_entry_t      head_e;
   logic [ID_W-1:0] head_id;
   logic            fifo_pop;
   logic            fifo_empty;
   logic            fifo_full;
   logic [CW-1:0]   fifo_cnt;
   logic [EW-1:0]   fifo_rdata;
   logic            unused_head;

   assign can_gnt = rst_n & ~mc_rq_stall & (|req_vld)
                  & (outst < OW'(MAX_OUTST));

   // Scan downward so the closest valid at/after the pointer wins
   always_comb begin
      logic [ID_W-1:0] idx;
      idx     = '0;
      gnt_vld = 1'b0;
      gnt_id  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (req_vld[idx]) begin
            gnt_vld = can_gnt;
            gnt_id  = idx;
         end
      end
   end

   assign req_rdy     = gnt_vld ? (NUM_REQ'(1) << gnt_id) : '0;
   assign mc_rq_flush = 1'b0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr       <= '0;
         mc_rq_vld    <= 1'b0;
         mc_rq_cmd    <= '0;
         mc_rq_scmd   <= '0;
         mc_rq_vadr   <= '0;
         mc_rq_size   <= '0;
         mc_rq_data   <= '0;
         mc_rq_rtnctl <= '0;
      end else begin
         mc_rq_vld <= gnt_vld;
         if (gnt_vld) begin
            rr_ptr       <= ID_W'((int'(gnt_id) + 1) % NUM_REQ);
            mc_rq_cmd    <= req_cmd[gnt_id*3 +: 3];
            mc_rq_scmd   <= req_scmd[gnt_id*4 +: 4];
            mc_rq_vadr   <= req_vadr[gnt_id*48 +: 48];
            mc_rq_size   <= req_size[gnt_id*2 +: 2];
            mc_rq_data   <= req_data[gnt_id*64 +: 64];
            mc_rq_rtnctl <= {gnt_id, req_rtnctl[gnt_id*LW +: LW]};
         end
      end
   end

   always_comb begin
      push_e        = '0;
      push_e.id     = ID_MAX'(mc_rs_rtnctl[RTNCTL_WIDTH-1 -: ID_W]);
      push_e.cmd    = mc_rs_cmd;
      push_e.scmd   = mc_rs_scmd;
      push_e.data   = mc_rs_data;
      push_e.rtnctl = RTN_MAX'(mc_rs_rtnctl[LW-1:0]);
   end

   mc_rsp_fifo #(
      .W     (EW),
      .DEPTH (RSP_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (mc_rs_vld),
      .wdata (push_e),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .count (fifo_cnt),
      .full  (fifo_full),
      .empty (fifo_empty),
      .ovf   (err_ovf)
   );

   assign head_e      = rsp_entry_t'(fifo_rdata);
   assign head_id     = head_e.id[ID_W-1:0];
   assign fifo_pop    = ~fifo_empty & ~rsp_stall[head_id];
   assign rsp_vld     = fifo_empty ? '0 : (NUM_REQ'(1) << head_id);
   assign rsp_cmd     = head_e.cmd;
   assign rsp_scmd    = head_e.scmd;
   assign rsp_data    = head_e.data;
   assign rsp_rtnctl  = head_e.rtnctl[LW-1:0];
   assign unused_head = ^{head_e.id, head_e.rtnctl, fifo_full};

   // A pop with nothing outstanding is a stray response; never wrap
   assign outst_dec = fifo_pop & (outst != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         outst       <= '0;
         mc_rs_stall <= 1'b0;
         idle        <= 1'b1;
      end else begin
         if (gnt_vld & ~outst_dec)      outst <= outst + OW'(1);
         else if (~gnt_vld & outst_dec) outst <= outst - OW'(1);
         mc_rs_stall <= (fifo_cnt >= CW'(RSP_DEPTH - RS_SLACK));
         idle        <= ~|req_vld & ~mc_rq_vld & fifo_empty
                      & (outst == '0);
      end
   end

endmodule

// File: tb/tb_mc_port_arbiter.sv
// Directed bench for mc_port_arbiter with hand-computed expectations.
// Runs with MAX_OUTST=4 so the outstanding limit is reachable.
module tb_mc_port_arbiter;
   import mc_arb_pkg::*;

   localparam int NR = 4;
   localparam int RW = 32;
   localparam int IW = 2;
   localparam int LW = RW - IW;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     req_vld;
   logic [NR*3-1:0]   req_cmd;
   logic [NR*4-1:0]   req_scmd;
   logic [NR*48-1:0]  req_vadr;
   logic [NR*2-1:0]   req_size;
   logic [NR*64-1:0]  req_data;
   logic [NR*LW-1:0]  req_rtnctl;
   logic [NR-1:0]     req_rdy;
   logic [NR-1:0]     rsp_vld;
   logic [2:0]        rsp_cmd;
   logic [3:0]        rsp_scmd;
   logic [63:0]       rsp_data;
   logic [LW-1:0]     rsp_rtnctl;
   logic [NR-1:0]     rsp_stall;
   logic              mc_rq_vld;
   logic [2:0]        mc_rq_cmd;
   logic [3:0]        mc_rq_scmd;
   logic [47:0]       mc_rq_vadr;
   logic [1:0]        mc_rq_size;
   logic [63:0]       mc_rq_data;
   logic [RW-1:0]     mc_rq_rtnctl;
   logic              mc_rq_stall;
   logic              mc_rq_flush;
   logic              mc_rs_vld;
   logic [2:0]        mc_rs_cmd;
   logic [3:0]        mc_rs_scmd;
   logic [63:0]       mc_rs_data;
   logic [RW-1:0]     mc_rs_rtnctl;
   logic              mc_rs_stall;
   logic              idle;
   logic              err_ovf;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mc_port_arbiter #(
      .NUM_REQ      (NR),
      .RTNCTL_WIDTH (RW),
      .ID_W         (IW),
      .RSP_DEPTH    (8),
      .RS_SLACK     (3),
      .MAX_OUTST    (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_vld      (req_vld),
      .req_cmd      (req_cmd),
      .req_scmd     (req_scmd),
      .req_vadr     (req_vadr),
      .req_size     (req_size),
      .req_data     (req_data),
      .req_rtnctl   (req_rtnctl),
      .req_rdy      (req_rdy),
      .rsp_vld      (rsp_vld),
      .rsp_cmd      (rsp_cmd),
      .rsp_scmd     (rsp_scmd),
      .rsp_data     (rsp_data),
      .rsp_rtnctl   (rsp_rtnctl),
      .rsp_stall    (rsp_stall),
      .mc_rq_vld    (mc_rq_vld),
      .mc_rq_cmd    (mc_rq_cmd),
      .mc_rq_scmd   (mc_rq_scmd),
      .mc_rq_vadr   (mc_rq_vadr),
      .mc_rq_size   (mc_rq_size),
      .mc_rq_data   (mc_rq_data),
      .mc_rq_rtnctl (mc_rq_rtnctl),
      .mc_rq_stall  (mc_rq_stall),
      .mc_rq_flush  (mc_rq_flush),
      .mc_rs_vld    (mc_rs_vld),
      .mc_rs_cmd    (mc_rs_cmd),
      .mc_rs_scmd   (mc_rs_scmd),
      .mc_rs_data   (mc_rs_data),
      .mc_rs_rtnctl (mc_rs_rtnctl),
      .mc_rs_stall  (mc_rs_stall),
      .idle         (idle),
      .err_ovf      (err_ovf)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_rsp(input int id, input logic [63:0] d);
      logic [IW-1:0] idb;
      idb          = IW'(id);
      mc_rs_vld    = 1'b1;
      mc_rs_cmd    = MC_RS_RDRSP;
      mc_rs_scmd   = 4'h0;
      mc_rs_data   = d;
      mc_rs_rtnctl = {idb, LW'(32'h100 + id)};
      tick();
      mc_rs_vld    = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      req_vld      = '0;
      req_cmd      = '0;
      req_scmd     = '0;
      req_vadr     = '0;
      req_size     = '0;
      req_data     = '0;
      req_rtnctl   = '0;
      rsp_stall    = '0;
      mc_rq_stall  = 1'b0;
      mc_rs_vld    = 1'b0;
      mc_rs_cmd    = '0;
      mc_rs_scmd   = '0;
      mc_rs_data   = '0;
      mc_rs_rtnctl = '0;
      tick();
      tick();
      chk("rst_rq_vld", 64'(mc_rq_vld), 0);
      chk("rst_rq_vadr", 64'(mc_rq_vadr), 0);
      chk("rst_rs_stall", 64'(mc_rs_stall), 0);
      chk("rst_req_rdy", 64'(req_rdy), 0);
      chk("rst_rsp_vld", 64'(rsp_vld), 0);
      chk("rst_err_ovf", 64'(err_ovf), 0);
      chk("rst_idle", 64'(idle), 1);
      chk("flush", 64'(mc_rq_flush), 0);
      rst_n = 1'b1;
      tick();

      // single request from requester 2
      req_vld            = 4'b0100;
      req_vadr[2*48 +: 48]  = 48'h1000;
      req_cmd[2*3 +: 3]     = MC_CMD_RD8;
      req_rtnctl[2*LW +: LW] = LW'(5);
      #1;
      chk("single_rdy", 64'(req_rdy), 64'h4);
      tick();
      req_vld = '0;
      chk("single_vld", 64'(mc_rq_vld), 1);
      chk("single_vadr", 64'(mc_rq_vadr), 64'h1000);
      chk("single_cmd", 64'(mc_rq_cmd), 64'(MC_CMD_RD8));
      chk("single_id", 64'(mc_rq_rtnctl[31:30]), 2);
      chk("single_low", 64'(mc_rq_rtnctl[29:0]), 5);
      tick();
      chk("single_vld_drop", 64'(mc_rq_vld), 0);
      send_rsp(2, 64'hDEAD);
      chk("single_rsp_vld", 64'(rsp_vld), 64'h4);
      chk("single_rsp_data", rsp_data, 64'hDEAD);
      chk("single_rsp_rtn", 64'(rsp_rtnctl), 64'h102);
      chk("single_rsp_cmd", 64'(rsp_cmd), 64'(MC_RS_RDRSP));
      tick();
      chk("single_rsp_pop", 64'(rsp_vld), 0);

      // round robin from pointer 0, then outstanding limit of 4
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < NR; i++)
         req_vadr[i*48 +: 48] = 48'(32'h100 * (i + 1));
      req_vld = 4'hF;
      for (int g = 0; g < NR; g++) begin
         #1;
         chk($sformatf("rr_rdy%0d", g), 64'(req_rdy), 64'(1) << g);
         tick();
         chk($sformatf("rr_vld%0d", g), 64'(mc_rq_vld), 1);
         chk($sformatf("rr_id%0d", g), 64'(mc_rq_rtnctl[31:30]), 64'(g));
         chk($sformatf("rr_vadr%0d", g), 64'(mc_rq_vadr),
             64'(32'h100 * (g + 1)));
      end
      #1;
      chk("outst_block_rdy", 64'(req_rdy), 0);
      tick();
      chk("outst_block_vld", 64'(mc_rq_vld), 0);
      send_rsp(1, 64'h11);
      chk("outst_still_block", 64'(req_rdy), 0);
      chk("outst_rsp_vld", 64'(rsp_vld), 64'h2);
      tick();
      chk("outst_resume", 64'(req_rdy), 64'h1);
      tick();
      req_vld = '0;
      chk("outst_resume_id", 64'(mc_rq_rtnctl[31:30]), 0);
      for (int i = 0; i < NR; i++) send_rsp(i, 64'(i));
      repeat (4) tick();
      chk("drain_idle", 64'(idle), 1);

      // request stall holds off requester 1
      req_vld     = 4'b0010;
      mc_rq_stall = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("stall_rdy%0d", c), 64'(req_rdy), 0);
         tick();
         chk($sformatf("stall_vld%0d", c), 64'(mc_rq_vld), 0);
      end
      mc_rq_stall = 1'b0;
      #1;
      chk("unstall_rdy", 64'(req_rdy), 64'h2);
      tick();
      req_vld = '0;
      chk("unstall_vld", 64'(mc_rq_vld), 1);
      chk("unstall_id", 64'(mc_rq_rtnctl[31:30]), 1);
      send_rsp(1, 64'h21);
      tick();

      // stalled head blocks a later response
      rsp_stall = 4'b1000;
      send_rsp(3, 64'hA3);
      send_rsp(0, 64'hA0);
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("hol_vld%0d", c), 64'(rsp_vld), 64'h8);
         tick();
      end
      rsp_stall = '0;
      #1;
      chk("hol_last", 64'(rsp_vld), 64'h8);
      chk("hol_data3", rsp_data, 64'hA3);
      tick();
      chk("hol_next_vld", 64'(rsp_vld), 64'h1);
      chk("hol_next_data", rsp_data, 64'hA0);
      chk("hol_next_rtn", 64'(rsp_rtnctl), 64'h100);
      tick();
      chk("hol_empty", 64'(rsp_vld), 0);

      // fill to overflow with every requester stalled
      rsp_stall = 4'hF;
      for (int k = 1; k <= 9; k++) begin
         send_rsp(k % NR, 64'(32'h200 + k));
         if (k == 5) chk("rs_stall_c5", 64'(mc_rs_stall), 0);
         if (k == 6) chk("rs_stall_c6", 64'(mc_rs_stall), 1);
         if (k == 8) chk("ovf_at8", 64'(err_ovf), 0);
         if (k == 9) chk("ovf_at9", 64'(err_ovf), 1);
      end
      chk("ovf_head", rsp_data, 64'h201);
      rsp_stall = '0;
      tick();
      chk("ovf_sticky", 64'(err_ovf), 1);
      chk("ovf_next", rsp_data, 64'h202);

      // reset mid-traffic, then a late response is accepted
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("ovf_clear", 64'(err_ovf), 0);
      chk("fifo_clear", 64'(rsp_vld), 0);
      req_vld = 4'hF;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rdy", 64'(req_rdy), 0);
      tick();
      chk("mid_rst_vld", 64'(mc_rq_vld), 0);
      chk("mid_rst_idle", 64'(idle), 1);
      rst_n   = 1'b1;
      req_vld = '0;
      send_rsp(2, 64'hBEEF);
      chk("late_rsp_vld", 64'(rsp_vld), 64'h4);
      chk("late_rsp_data", rsp_data, 64'hBEEF);
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
